// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered MDU results.
// Optional same-cycle MDU bypass into an idle port: define WB_ARB_BYPASS_EN.
module wb_port_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_valid,
    input  logic [4:0]               pipe_rd,
    input  logic [31:0]              pipe_data,
    output logic                     pipe_stall,
    input  logic                     mdu_valid,
    output logic                     mdu_ready,
    input  logic [4:0]               mdu_rd,
    input  logic [31:0]              mdu_data,
    output logic                     rf_we,
    output logic [4:0]               rf_rd,
    output logic [31:0]              rf_wdata,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [WW-1:0]   wait_cnt;
    logic            empty, full, pipe_req, accept, push, pop, bypass;
    logic            grant_fifo, grant_pipe;

    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign head       = mem[rd_ptr];
    assign pipe_req   = pipe_valid && (pipe_rd != 5'd0);
    assign mdu_ready  = !full && !rst;
    assign accept     = mdu_valid && mdu_ready;

    assign grant_fifo = !empty && (!pipe_req || wait_cnt == WW'(MAX_WAIT));
    assign grant_pipe = !grant_fifo && pipe_req;
    assign pipe_stall = pipe_req && grant_fifo && !rst;

`ifdef WB_ARB_BYPASS_EN
    assign bypass = accept && (mdu_rd != 5'd0) && empty && !pipe_req;
`else
    assign bypass = 1'b0;
`endif

    // rd==0 MDU results finish the handshake but are dropped here
    assign push = accept && (mdu_rd != 5'd0) && !bypass;
    assign pop  = grant_fifo;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{rd: mdu_rd, data: mdu_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wait_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (empty || pop)
                wait_cnt <= '0;
            else if (wait_cnt != WW'(MAX_WAIT))
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Address/data hold their last value on idle cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= grant_fifo || grant_pipe || bypass;
            if (grant_fifo) begin
                rf_rd    <= head.rd;
                rf_wdata <= head.data;
            end else if (grant_pipe) begin
                rf_rd    <= pipe_rd;
                rf_wdata <= pipe_data;
            end else if (bypass) begin
                rf_rd    <= mdu_rd;
                rf_wdata <= mdu_data;
            end
        end
    end

    assign fifo_count = count;
endmodule
